// File: rtl/oam_sprite_evaluator.sv
// Per-scanline OAM scanner: walks every OAM entry through a 1-cycle synchronous read
// port and collects the sprites covering the target line into a small line buffer.
module oam_sprite_evaluator #(
  parameter int OAM_ENTRIES   = 64,
  parameter int MAX_SPRITES   = 8,
  parameter int SPRITE_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  target_line,
  output logic [5:0]  oam_read_addr,
  input  logic [31:0] oam_read_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count,
  output logic        overflow,
  input  logic [2:0]  slot_idx,
  output logic [31:0] slot_data,
  output logic [3:0]  slot_row
);

  localparam logic [5:0] LAST_ADDR = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);
  localparam logic [8:0] HEIGHT9   = 9'(SPRITE_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t      state, next_state;
  logic        accept, last_eval, hit;
  logic [8:0]  diff;
  logic [7:0]  tgt;
  logic        addr_valid, data_valid;
  logic [5:0]  data_idx;
  logic [35:0] slots [MAX_SPRITES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_eval  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (data_valid && data_idx == LAST_ADDR) begin
          last_eval  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // A borrow out of the 9-bit subtraction means Y lies below the line, so no wrap-around hits.
  always_comb begin
    diff = {1'b0, tgt} - {1'b0, oam_read_data[31:24]};
    hit  = (state == ST_SCAN) && data_valid && !diff[8] && (diff < HEIGHT9);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oam_read_addr <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sprite_count  <= '0;
      overflow      <= 1'b0;
      tgt           <= '0;
      addr_valid    <= 1'b0;
      data_valid    <= 1'b0;
      data_idx      <= '0;
      for (int s = 0; s < MAX_SPRITES; s++) slots[s] <= '0;
    end else begin
      busy <= (next_state != ST_IDLE);
      done <= (next_state == ST_DONE);
      if (accept) begin
        tgt           <= target_line;
        sprite_count  <= '0;
        overflow      <= 1'b0;
        oam_read_addr <= '0;
        addr_valid    <= 1'b1;
        data_valid    <= 1'b0;
        data_idx      <= '0;
        for (int s = 0; s < MAX_SPRITES; s++) slots[s] <= '0;
      end else if (state == ST_SCAN) begin
        // data_idx names the entry whose word arrives on the read port next cycle
        data_valid <= addr_valid && !last_eval;
        data_idx   <= oam_read_addr;
        if (addr_valid) begin
          if (oam_read_addr != LAST_ADDR) oam_read_addr <= oam_read_addr + 6'd1;
          else                            addr_valid    <= 1'b0;
        end
        if (hit) begin
          if (sprite_count < MAX_CNT) begin
            slots[sprite_count[2:0]] <= {oam_read_data, diff[3:0]};
            sprite_count             <= sprite_count + 4'd1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    slot_data = '0;
    slot_row  = '0;
    if ({1'b0, slot_idx} < sprite_count) begin
      slot_data = slots[slot_idx][35:4];
      slot_row  = slots[slot_idx][3:0];
    end
  end

endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Self-checking bench for oam_sprite_evaluator: directed cases plus randomized OAM
// contents, compared against a simple list-building model of the hit rule.
module tb_oam_sprite_evaluator;

  localparam int HEIGHT = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  target_line;
  logic [5:0]  oam_read_addr;
  logic [31:0] oam_read_data;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic        overflow;
  logic [2:0]  slot_idx;
  logic [31:0] slot_data;
  logic [3:0]  slot_row;

  logic [31:0] oam_mem [64];
  int          vectors;
  int          miscompares;

  int          exp_count;
  int          exp_ovf;
  logic [31:0] exp_word [8];
  logic [3:0]  exp_row [8];

  oam_sprite_evaluator #(
    .OAM_ENTRIES(64),
    .MAX_SPRITES(8),
    .SPRITE_HEIGHT(HEIGHT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .target_line(target_line),
    .oam_read_addr(oam_read_addr),
    .oam_read_data(oam_read_data),
    .busy(busy),
    .done(done),
    .sprite_count(sprite_count),
    .overflow(overflow),
    .slot_idx(slot_idx),
    .slot_data(slot_data),
    .slot_row(slot_row)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous OAM read port with one cycle of latency
  always @(posedge clk) oam_read_data <= oam_mem[oam_read_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: walk OAM in index order and keep the first eight covering sprites
  task automatic computeModel(input logic [7:0] tgt);
    int y;
    exp_count = 0;
    exp_ovf   = 0;
    for (int s = 0; s < 8; s++) begin
      exp_word[s] = '0;
      exp_row[s]  = '0;
    end
    for (int i = 0; i < 64; i++) begin
      y = int'(oam_mem[i][31:24]);
      if (y <= int'(tgt) && int'(tgt) - y < HEIGHT) begin
        if (exp_count < 8) begin
          exp_word[exp_count] = oam_mem[i];
          exp_row[exp_count]  = 4'(int'(tgt) - y);
          exp_count++;
        end else begin
          exp_ovf = 1;
        end
      end
    end
  endtask

  task automatic fillOam(input logic [7:0] y);
    logic [31:0] r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom();
      oam_mem[i] = {y, r[23:0]};
    end
  endtask

  task automatic verifyResults(input string tag);
    checkOutput({tag, " count"}, 32'(sprite_count), 32'(exp_count));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    for (int s = 0; s < 8; s++) begin
      slot_idx = 3'(s);
      #1;
      checkOutput($sformatf("%s slot%0d data", tag, s), slot_data, exp_word[s]);
      checkOutput($sformatf("%s slot%0d row", tag, s), 32'(slot_row), 32'(exp_row[s]));
    end
  endtask

  // Runs one scan; optionally pulses a second start with another line at restart_at
  task automatic applyStimulus(input string tag, input logic [7:0] tgt, input int restart_at, input logic [7:0] tgt2);
    int cyc;
    int done_cyc;
    int pulses;
    @(negedge clk);
    start       = 1'b1;
    target_line = tgt;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    cyc      = 0;
    done_cyc = -1;
    pulses   = 0;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (cyc == restart_at) target_line = tgt2;
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          checkOutput({tag, " busy at done"}, 32'(busy), 32'd1);
        end
      end
    end
    start = 1'b0;
    checkOutput({tag, " done cycle"}, 32'(done_cyc), 32'd65);
    checkOutput({tag, " done pulses"}, 32'(pulses), 32'd1);
    checkOutput({tag, " busy idle"}, 32'(busy), 32'd0);
    computeModel(tgt);
    verifyResults(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    target_line = '0;
    slot_idx    = '0;
    fillOam(8'hF0);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset count", 32'(sprite_count), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset addr", 32'(oam_read_addr), 32'd0);
    checkOutput("reset slot data", slot_data, 32'd0);
    checkOutput("reset slot row", 32'(slot_row), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    fillOam(8'hF0);
    applyStimulus("empty", 8'h10, -1, 8'h00);

    fillOam(8'hF0);
    oam_mem[3]  = 32'h20112233;
    oam_mem[10] = 32'h20445566;
    applyStimulus("two", 8'h24, -1, 8'h00);
    checkOutput("two slot1 direct", 32'h20445566, exp_word[1] == 32'h20445566 ? slot_data_at(1) : 32'hDEADBEEF);

    fillOam(8'hF0);
    oam_mem[0] = 32'h49A1A2A3;
    oam_mem[1] = 32'h48B1B2B3;
    oam_mem[2] = 32'h51C1C2C3;
    oam_mem[3] = 32'h50D1D2D3;
    applyStimulus("edges", 8'h50, -1, 8'h00);

    fillOam(8'hF0);
    for (int i = 0; i < 10; i++) oam_mem[i] = {8'h30, 8'(i), 16'h5A5A};
    applyStimulus("overflow", 8'h30, -1, 8'h00);

    fillOam(8'hF0);
    for (int i = 20; i < 26; i++) oam_mem[i] = {8'h60, 8'(i), 16'h1234};
    for (int i = 40; i < 44; i++) oam_mem[i] = {8'h90, 8'(i), 16'h4321};
    applyStimulus("restart", 8'h63, 20, 8'h92);

    // Mid-scan reset followed by a fresh full scan
    fillOam(8'hF0);
    for (int i = 0; i < 10; i++) oam_mem[i] = {8'h30, 8'(i), 16'hBEEF};
    @(negedge clk);
    start       = 1'b1;
    target_line = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset    = 1'b1;
    slot_idx = 3'd0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset count", 32'(sprite_count), 32'd0);
    checkOutput("midreset overflow", 32'(overflow), 32'd0);
    checkOutput("midreset slot", slot_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus("after reset", 8'h35, -1, 8'h00);

    for (int t = 0; t < 20; t++) begin
      logic [7:0]  tgt;
      logic [31:0] r;
      logic [7:0]  y;
      r   = $urandom();
      tgt = r[7:0];
      for (int i = 0; i < 64; i++) begin
        r = $urandom();
        if (r[31:30] == 2'b00) y = r[7:0];
        else                   y = tgt - 8'($urandom_range(0, 11 + t));
        oam_mem[i] = {y, r[23:0]};
      end
      applyStimulus($sformatf("rand%0d", t), tgt, (t % 4 == 0) ? 10 + t : -1, ~tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [31:0] slot_data_at(input int s);
    return dut.slots[s][35:4];
  endfunction

endmodule

// File: doc/oam_sprite_evaluator.md
Name: oam_sprite_evaluator

Overview:
- Per-scanline reader of the sprite attribute (OAM) store.
- On a start pulse, scans all 64 32-bit OAM entries through the OAM synchronous read port (1-cycle read latency).
- Selects the sprites whose vertical span covers the target scanline, up to MAX_SPRITES, into a local line buffer.
- The sprite renderer reads the line buffer during the next scanline.

Parameters:
- OAM_ENTRIES, 64: entries scanned; address width is 6.
- MAX_SPRITES, 8: line buffer depth (slots).
- SPRITE_HEIGHT, 8: sprite height in lines; legal values 8 or 16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to evaluate target_line; honoured only in IDLE.
- target_line  input  8  scanline to evaluate; sampled on the edge that accepts start.
- oam_read_addr  output  6  registered OAM read address.
- oam_read_data  input  32  OAM word; valid one cycle after its address. Format: [31:24] Y, [23:16] tile, [15:8] attributes, [7:0] X.
- busy  output  1  high from the accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the scan completes.
- sprite_count  output  4  number of valid slots, 0..MAX_SPRITES.
- overflow  output  1  more than MAX_SPRITES hits on this line.
- slot_idx  input  3  line buffer read index.
- slot_data  output  32  OAM word stored in slot slot_idx; combinational read.
- slot_row  output  4  row within the sprite: target_line - Y for that slot.

Behaviour:
- Reset (async): state IDLE; oam_read_addr=0, busy=0, done=0, sprite_count=0, overflow=0; all slots cleared to 0 (slot_data=0, slot_row=0).
- State IDLE:
  - start=1 on an edge E0: latch target_line; clear count, overflow and all slots; oam_read_addr<=0; busy<=1; go to SCAN.
- State SCAN:
  - oam_read_addr increments by 1 each cycle and saturates at 63.
  - A 1-bit valid pipeline tracks outstanding reads: entry k is evaluated on edge E(k+2).
  - Last evaluation is entry 63 on E65. That edge sets done<=1 and moves to DONE.
- State DONE: lasts one cycle. On E66: done<=0, busy<=0, return to IDLE.
- Latency: done is high during the cycle after E65, i.e. 65 cycles after the accepted start edge.
- Hit rule: 9-bit unsigned diff = {0,target_line} - {0,Y}. Hit iff Y <= target_line and diff < SPRITE_HEIGHT. No wrap-around: Y > target_line is never a hit.
- On a hit with count < MAX_SPRITES:
  - slot[count] <= {word, diff[3:0]}; count += 1.
  - Slots fill in ascending OAM index order.
- On a hit with count == MAX_SPRITES: overflow <= 1; word discarded; count unchanged; scan continues to entry 63.
- Outputs during and after the scan:
  - sprite_count updates live during the scan.
  - Slots, count and overflow hold after done until the next accepted start.
  - slot_idx >= sprite_count returns 0 on slot_data and slot_row.
- start while busy (SCAN or DONE): ignored; no restart, no effect on latched target_line.
- reset mid-scan: immediate return to reset values; a later start performs a full fresh scan.
- X, tile and attribute bytes are never interpreted, only stored.

Test Plan:
- OAM all Y=0xF0, start with target_line=0x10 -> done 65 cycles after start; sprite_count=0, overflow=0; slot_data(0)=0.
- Entries 3 and 10 have Y=0x20 (entry 3 word 0x20_11_22_33, entry 10 word 0x20_44_55_66), target_line=0x24 -> count=2; slot0=0x20112233 with row 4; slot1=0x20445566 with row 4; slot_idx=2 returns 0.
- SPRITE_HEIGHT=8, target_line=0x50:
  - Y=0x49 -> hit, row 7.
  - Y=0x48 -> miss.
  - Y=0x51 -> miss.
  - Y=0x50 -> hit, row 0.
- Entries 0..9 all Y=0x30, target_line=0x30 -> count=8; overflow=1; slots hold entries 0..7 in order; done still at cycle 65.
- Second start pulse at cycle 20 of a scan with a different target_line -> ignored; results match the first target; exactly one done pulse.
- Assert reset at cycle 30 of a scan -> busy, count and overflow go to 0 immediately. A new start then yields the correct full result.
